// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with IF/ID pipeline register.
// Owns the PC, issues word fetches over a req/ack handshake, and buffers one
// response in a skid register while decode is stalled. Redirects flush IF/ID.
// A fetch that is in flight when a redirect arrives still completes, and its
// data is thrown away.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7
);

    localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] drop_addr;
    logic [31:0] skid_instr, skid_pc;
    logic [31:0] target;

    // Datapath control decoded from the FSM.
    logic        load_mem;   // IF/ID <= memory response
    logic        load_skid;  // skid  <= memory response
    logic        skid_to_id; // IF/ID <= skid buffer
    logic        flush;      // IF/ID <= bubble (redirect)
    logic        bubble;     // nothing new for decode this cycle
    logic        latch_drop; // remember address of the killed fetch

    // Redirect targets are always word aligned; the low two bits are masked off.
    assign target = redirect_pc & ~32'h0000_0003;

    // State register.
    // NOTE: sequential state is written with non-blocking (<=) so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state, next-PC and datapath control; redirect has top priority.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_mem   = 1'b0;
        load_skid  = 1'b0;
        skid_to_id = 1'b0;
        flush      = 1'b0;
        bubble     = 1'b0;
        latch_drop = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                if (redirect_valid) begin
                    pc_next = target;
                    flush   = 1'b1;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next = target;
                    flush   = 1'b1;
                    if (!imem_ack) begin
                        // The fetch stays on the bus at its old address.
                        state_next = S_DROP;
                        latch_drop = 1'b1;
                    end
                end else if (imem_ack) begin
                    pc_next = pc + 32'd4;
                    if (stall) begin
                        load_skid  = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        load_mem = 1'b1;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = target;
                    flush      = 1'b1;
                    state_next = S_REQ;
                end else if (!stall) begin
                    skid_to_id = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_next = target;
                    flush   = 1'b1;
                end
                if (imem_ack) state_next = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Memory request outputs: a killed fetch keeps its original address.
    always_comb begin
        imem_req  = (state == S_REQ) || (state == S_DROP);
        imem_addr = (state == S_DROP) ? drop_addr : pc;
    end

    // PC, skid buffer and drop address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc         <= RESET_PC;
            drop_addr  <= 32'h0;
            skid_instr <= NOP;
            skid_pc    <= 32'h0;
        end else begin
            pc <= pc_next;
            if (latch_drop) drop_addr <= pc;
            if (load_skid) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

    // IF/ID pipeline register: flush, load from memory, load from skid, or bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP;
            id_pc       <= 32'h0;
            id_pc_plus4 <= 32'd4;
        end else if (flush || bubble) begin
            id_valid <= 1'b0;
            id_instr <= NOP;
        end else if (load_mem) begin
            id_valid    <= 1'b1;
            id_instr    <= imem_rdata;
            id_pc       <= pc;
            id_pc_plus4 <= pc + 32'd4;
        end else if (skid_to_id) begin
            id_valid    <= 1'b1;
            id_instr    <= skid_instr;
            id_pc       <= skid_pc;
            id_pc_plus4 <= skid_pc + 32'd4;
        end
    end

    // Pre-split fields for the control unit.
    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle table for the handshake/stall/redirect corners,
// a scoreboarded random wait/stall stream, and a wrap-around PC instance.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        resetn;
    logic        imem_req, imem_ack, redirect_valid, stall, id_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_pc, id_pc_plus4, id_instr;
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;

    // Second instance: reset PC at the top of the address space.
    logic        req2, ack2, rdv2, stall2, valid2;
    logic [31:0] addr2, rdata2, rpc2, pc2, plus4_2, instr2;
    logic [6:0]  op2, f7_2;
    logic [2:0]  f3_2;

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory model: data is a fixed function of the address.
    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);
    assign ack2       = 1'b1;
    assign rdv2       = 1'b0;
    assign stall2     = 1'b0;
    assign rpc2       = 32'h0;

    fetch_stage dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall(stall), .id_valid(id_valid),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .resetn(resetn),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(rdata2), .redirect_valid(rdv2),
        .redirect_pc(rpc2), .stall(stall2), .id_valid(valid2),
        .id_pc(pc2), .id_pc_plus4(plus4_2), .id_instr(instr2),
        .id_opcode(op2), .id_funct3(f3_2), .id_funct7(f7_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Reset asserted mid-cycle (possibly mid-request), released on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        check({tag, "_rst_req"},   {31'h0, imem_req}, 32'h0);
        check({tag, "_rst_valid"}, {31'h0, id_valid}, 32'h0);
        check({tag, "_rst_instr"}, id_instr, NOP);
        check({tag, "_rst_pc"},    id_pc, 32'h0);
        check({tag, "_rst_pc4"},   id_pc_plus4, 32'd4);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic        ack, stall, rdv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t v(input logic ack, input logic stl, input logic rdv,
                               input logic [31:0] rpc, input logic er,
                               input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei);
        vec_t r;
        r.ack = ack; r.stall = stl; r.rdv = rdv; r.rpc = rpc;
        r.e_req = er; r.e_addr = ea; r.e_valid = ev; r.e_pc = ep; r.e_instr = ei;
        return r;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] exp_addr;
    int          last_pop;
    bit          have_pop;

    // Pop one expected instruction whenever IF/ID was freshly loaded.
    task automatic monitor_step(input bit fixed, input int cyc);
        exp_t e;
        if (id_valid && !stall) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_valid", {31'h0, id_valid}, 32'h0);
            end else begin
                e = sbq.pop_front();
                check("sb_pc",    id_pc, e.pc);
                check("sb_instr", id_instr, e.instr);
                check("sb_pc4",   id_pc_plus4, e.pc + 32'd4);
                if (fixed && have_pop) check("sb_gap", cyc - last_pop, 32'd3);
                last_pop = cyc;
                have_pop = 1'b1;
            end
        end
    endtask

    vec_t vecs[24];

    initial begin
        int wait_cnt, wait_tgt;
        bit fixed;

        resetn = 1'b0;
        imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // ack, stall, redirect, rpc | req, addr, valid, id_pc, id_instr
        vecs[0]  = v(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   NOP);
        vecs[1]  = v(1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   NOP);
        vecs[2]  = v(1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0,   mem_word(32'h0));
        vecs[3]  = v(1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h4,   mem_word(32'h4));
        vecs[4]  = v(1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h8,   mem_word(32'h8));
        vecs[5]  = v(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   mem_word(32'h8));
        vecs[6]  = v(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   mem_word(32'h8));
        vecs[7]  = v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8,   mem_word(32'h8));
        vecs[8]  = v(0, 0, 0, 32'h0,   1, 32'h10,  1, 32'hC,   mem_word(32'hC));
        vecs[9]  = v(0, 0, 0, 32'h0,   1, 32'h10,  0, 32'h0,   NOP);
        vecs[10] = v(1, 0, 0, 32'h0,   1, 32'h10,  0, 32'h0,   NOP);
        vecs[11] = v(1, 0, 0, 32'h0,   1, 32'h14,  1, 32'h10,  mem_word(32'h10));
        vecs[12] = v(1, 0, 0, 32'h0,   1, 32'h18,  1, 32'h14,  mem_word(32'h14));
        vecs[13] = v(1, 0, 0, 32'h0,   1, 32'h1C,  1, 32'h18,  mem_word(32'h18));
        vecs[14] = v(0, 0, 1, 32'h103, 1, 32'h20,  1, 32'h1C,  mem_word(32'h1C));
        vecs[15] = v(0, 0, 0, 32'h0,   1, 32'h20,  0, 32'h0,   NOP);
        vecs[16] = v(1, 0, 0, 32'h0,   1, 32'h20,  0, 32'h0,   NOP);
        vecs[17] = v(1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   NOP);
        vecs[18] = v(1, 1, 1, 32'h200, 1, 32'h104, 1, 32'h100, mem_word(32'h100));
        vecs[19] = v(1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0,   NOP);
        vecs[20] = v(0, 0, 1, 32'h300, 1, 32'h204, 1, 32'h200, mem_word(32'h200));
        vecs[21] = v(0, 0, 1, 32'h40C, 1, 32'h204, 0, 32'h0,   NOP);
        vecs[22] = v(1, 0, 0, 32'h0,   1, 32'h204, 0, 32'h0,   NOP);
        vecs[23] = v(0, 0, 0, 32'h0,   1, 32'h40C, 0, 32'h0,   NOP);

        // Cycle table: check outputs of the current cycle, then drive its inputs.
        do_reset("tbl");
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("row%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].e_req)
                check($sformatf("row%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("row%0d_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("row%0d_instr", i), id_instr, vecs[i].e_instr);
            check($sformatf("row%0d_fields", i), {15'h0, id_funct7, id_funct3, id_opcode},
                  {15'h0, vecs[i].e_instr[31:25], vecs[i].e_instr[14:12], vecs[i].e_instr[6:0]});
            if (vecs[i].e_valid || i == 0) begin
                check($sformatf("row%0d_pc", i),  id_pc, vecs[i].e_pc);
                check($sformatf("row%0d_pc4", i), id_pc_plus4, vecs[i].e_pc + 32'd4);
            end
            imem_ack       = vecs[i].ack;
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rdv;
            redirect_pc    = vecs[i].rpc;
        end

        // Scoreboarded stream: fixed 2-cycle waits first, then random waits and stalls.
        do_reset("sb");
        exp_addr = 32'h0;
        wait_cnt = 0;
        wait_tgt = 2;
        have_pop = 1'b0;
        last_pop = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            fixed = (cyc < 30);
            monitor_step(fixed, cyc);
            if (imem_req) begin
                check("sb_addr", imem_addr, exp_addr);
                if (wait_cnt >= wait_tgt) begin
                    imem_ack = 1'b1;
                    sbq.push_back({exp_addr, mem_word(exp_addr)});
                    exp_addr = exp_addr + 32'd4;
                    wait_cnt = 0;
                    wait_tgt = fixed ? 2 : int'($urandom_range(0, 2));
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
            end
            stall = fixed ? 1'b0 : ($urandom_range(0, 3) == 0);
        end
        for (int d = 0; d < 6; d++) begin
            @(negedge clk);
            monitor_step(1'b0, 300 + d);
            imem_ack = 1'b0;
            stall    = 1'b0;
        end
        check("sb_drained", sbq.size(), 32'd0);

        // Wrap-around PC on the second instance.
        do_reset("wrap");
        check("wrap_idle_req", {31'h0, req2}, 32'h0);
        @(negedge clk);
        check("wrap_req",   {31'h0, req2}, 32'h1);
        check("wrap_addr0", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_addr1", addr2, 32'h0000_0000);
        check("wrap_valid", {31'h0, valid2}, 32'h1);
        check("wrap_pc0",   pc2, 32'hFFFF_FFFC);
        check("wrap_pc4_0", plus4_2, 32'h0000_0000);
        check("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
        @(negedge clk);
        check("wrap_addr2", addr2, 32'h0000_0004);
        check("wrap_pc1",   pc2, 32'h0000_0000);
        check("wrap_pc4_1", plus4_2, 32'h0000_0004);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
